muldiv_seq: RTL and testbench

Multi-cycle unsigned multiply/divide unit placed beside the single-cycle ALU in the execute stage. A one-cycle `start` request launches a radix-2 sequence: shift-add for multiply, restoring shift-subtract for divide. Results go to HI/LO registers in MIPS MULTU/DIVU style. The control FSM signals `busy` while running and pulses `done` when HI/LO are updated.

---
 rtl/muldiv_seq.sv | 69 ++++++
 tb/tb_muldiv_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle radix-2 unsigned multiply/divide writing HI/LO, MULTU/DIVU style.
module muldiv_seq #(
  parameter int wordLen = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               op,
  input  logic [wordLen-1:0] A,
  input  logic [wordLen-1:0] B,
  output logic [wordLen-1:0] hi,
  output logic [wordLen-1:0] lo,
  output logic               busy,
  output logic               done,
  output logic               divZero
);
  localparam int CW = $clog2(wordLen) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [wordLen:0] acc, acc_n, sum, sh, t;
  logic [wordLen-1:0] q, q_n, b_r;
  logic op_r, load, last;
  logic [CW-1:0] cnt;
  assign load = start && state != CALC;
  assign last = state == CALC && cnt == CW'(1);
  assign busy = state == CALC;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = load ? CALC : last ? DONE : state == DONE ? IDLE : state;
  end
  // One shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle.
  always_comb begin
    sum = q[0] ? {1'b0, acc[wordLen-1:0]} + {1'b0, b_r} : acc;
    sh = {acc[wordLen-1:0], q[wordLen-1]};
    t = sh - {1'b0, b_r};
    acc_n = op_r ? (t[wordLen] ? sh : t) : {1'b0, sum[wordLen:1]};
    q_n = op_r ? {q[wordLen-2:0], ~t[wordLen]} : {sum[0], q[wordLen-1:1]};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      q <= '0;
      b_r <= '0;
      op_r <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      divZero <= 1'b0;
    end else if (load) begin
      op_r <= op;
      b_r <= B;
      q <= A;
      acc <= '0;
      cnt <= CW'(wordLen);
    end else if (state == CALC) begin
      acc <= acc_n;
      q <= q_n;
      cnt <= cnt - CW'(1);
      if (last) begin
        hi <= acc_n[wordLen-1:0];
        lo <= q_n;
        divZero <= op_r && b_r == '0;
      end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and random MULTU/DIVU checks against an arithmetic reference model.
module tb_muldiv_seq;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] A = '0, B = '0, hi, lo;
  logic busy, done, divZero;
  int vectors = 0, miscompares = 0, pulses;
  logic [2*W:0] r;

  muldiv_seq #(.wordLen(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .divZero(divZero)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W:0] model(input logic o, input logic [W-1:0] a, b);
    logic [2*W-1:0] p;
    if (!o) begin
      p = a * b;
      return {1'b0, p};
    end
    if (b == 0) return {1'b1, a, {W{1'b1}}};
    return {1'b0, W'(a % b), W'(a / b)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic o, input logic [W-1:0] a, b);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    op = 1'($urandom);
  endtask

  // Entered one cycle after the start edge; returns in the done cycle.
  task automatic finish_op(input string tag, input logic o, input logic [W-1:0] a, b);
    logic [2*W:0] m;
    m = model(o, a, b);
    for (int i = 0; i < W; i++) begin
      check({tag, "_busy"}, {30'd0, busy, done}, 32'b10);
      @(negedge clk);
    end
    check({tag, "_done"}, {30'd0, busy, done}, 32'b01);
    check({tag, "_res"}, {15'd0, divZero, hi, lo}, {15'd0, m});
  endtask

  initial begin
    #1;
    check("reset0", {13'd0, busy, done, divZero, hi, lo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle", {30'd0, busy, done}, 32'd0);

    launch(1'b0, 8'd13, 8'd11);
    finish_op("mul13x11", 1'b0, 8'd13, 8'd11);
    check("mul13x11_lo", {24'd0, lo}, 32'h8F);
    @(negedge clk);

    launch(1'b0, 8'hFF, 8'hFF);
    finish_op("mulmax", 1'b0, 8'hFF, 8'hFF);
    launch(1'b1, 8'd200, 8'd7);
    finish_op("div200_7", 1'b1, 8'd200, 8'd7);
    check("div200_7_hl", {16'd0, hi, lo}, 32'h041C);
    @(negedge clk);

    launch(1'b1, 8'd5, 8'd0);
    finish_op("div0", 1'b1, 8'd5, 8'd0);
    check("div0_flag", {23'd0, divZero, hi, lo}, 32'h105FF);
    @(negedge clk);
    launch(1'b0, 8'd2, 8'd3);
    finish_op("mul2x3", 1'b0, 8'd2, 8'd3);
    @(negedge clk);

    launch(1'b0, 8'd3, 8'd4);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op = 1'b1;
    A = 8'd9;
    B = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ign_done", {30'd0, busy, done}, 32'b01);
    check("ign_res", {15'd0, divZero, hi, lo}, {15'd0, model(1'b0, 8'd3, 8'd4)});
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(done);
    end
    check("ign_nosecond", pulses, 0);

    launch(1'b0, 8'd7, 8'd9);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {13'd0, busy, done, divZero, hi, lo}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      pulses += int'(done) + int'(busy);
    end
    check("rst_nodone", pulses, 0);
    launch(1'b1, 8'd17, 8'd5);
    finish_op("div17_5", 1'b1, 8'd17, 8'd5);
    check("div17_5_hl", {16'd0, hi, lo}, 32'h0203);

    for (int n = 0; n < 24; n++) begin
      logic o;
      logic [W-1:0] a, b;
      o = 1'($urandom);
      a = W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      launch(o, a, b);
      finish_op("rand", o, a, b);
    end

    r = {divZero, hi, lo};
    repeat (10) begin
      @(negedge clk);
      A = W'($urandom);
      B = W'($urandom);
      op = 1'($urandom);
      check("hold", {15'd0, busy, hi, lo}, {15'd0, 1'b0, r[2*W-1:0]});
      check("hold_dz", {31'd0, divZero}, {31'd0, r[2*W]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
